// File: rtl/fetch_decode_pipe.sv
// Fetch stage and IF/ID register for the 16-bit WISC pipeline.
// Optional PC alignment checking is enabled with `define FETCH_ALIGN_CHECK_EN.
module fetch_decode_pipe #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] instr_d,
  output logic [15:0] pc_plus2_d,
  output logic        valid_d,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc2_q, ifid_pc2_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] hold_q, hold_d;
  logic        err_q, err_d;

  logic [15:0] pc_eff, pc_next2;
  logic        misalign;

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_eff   = pc_q;
  assign misalign = pc_q[0];
`else
  logic unused_pc0;
  assign unused_pc0 = pc_q[0];
  assign pc_eff     = {pc_q[15:1], 1'b0};
  assign misalign   = 1'b0;
`endif

  assign pc_next2 = pc_eff + 16'd2;

  // Moore outputs; rst_n gating keeps the request low during reset cycles.
  assign imem_req   = rst_n & (state_q == S_FETCH) & ~misalign;
  assign imem_addr  = pc_eff;
  assign instr_d    = ifid_instr_q;
  assign pc_plus2_d = ifid_pc2_q;
  assign valid_d    = ifid_valid_q;
  assign halted     = (state_q == S_HALTED);
  assign err        = err_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc2_d   = ifid_pc2_q;
    ifid_valid_d = ifid_valid_q;
    hold_d       = hold_q;
    err_d        = err_q;
    if (redirect) begin
      pc_d         = redirect_pc;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      // An outstanding request whose done has not arrived must be drained.
      if (((state_q == S_FETCH) && !misalign && !imem_done) ||
          ((state_q == S_DISCARD) && !imem_done))
        state_d = S_DISCARD;
      else
        state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (misalign) begin
            err_d   = 1'b1;
            state_d = S_HALTED;
          end else if (imem_done) begin
            if (!stall) begin
              ifid_instr_d = imem_data;
              ifid_pc2_d   = pc_next2;
              ifid_valid_d = 1'b1;
              pc_d         = pc_next2;
              if (imem_data[15:11] == 5'b00000) state_d = S_HALTED;
            end else begin
              hold_d  = imem_data;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_instr_d = hold_q;
            ifid_pc2_d   = pc_next2;
            ifid_valid_d = 1'b1;
            pc_d         = pc_next2;
            state_d      = (hold_q[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_done) state_d = S_FETCH;
        end
        S_HALTED: begin
          if (!stall) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc2_q   <= 16'h0000;
      ifid_valid_q <= 1'b0;
      hold_q       <= NOP_INSTR;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc2_q   <= ifid_pc2_d;
      ifid_valid_q <= ifid_valid_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
    end
  end

endmodule
